// File: rtl/bus_target_if.sv
// Processor-side bus bundle for bus_target.
// The master is the processor, which drives the address, write data and strobe. The slave returns the registered read data.
interface bus_target_if;
    logic [15:0] Addr;
    logic [15:0] WrData;
    logic        W;
    logic [15:0] RdData;

    modport master (output Addr, output WrData, output W, input RdData);
    modport slave  (input Addr, input WrData, input W, output RdData);
endinterface

// File: rtl/bus_target.sv
// Memory-mapped responder for the processor bus. It holds the word RAM, the LEDs, the synchronized switches, a free-running timer and the console FIFO.
// Read data is registered, so every read has a fixed latency of one cycle.
module bus_target #(
    parameter int RAM_AW  = 8,
    parameter int FIFO_AW = 2
) (
    input  logic              Clock,
    input  logic              Clear,
    bus_target_if.slave       bus,
    input  logic [15:0]       SW,
    output logic [15:0]       led_out,
    output logic [15:0]       fifo_data,
    output logic              fifo_valid,
    input  logic              fifo_ready
);

    localparam int                 DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    logic [15:0]        ram [2 ** RAM_AW];
    logic [15:0]        fifo_mem [DEPTH];
    logic [RAM_AW-1:0]  ram_idx;
    logic [3:0]         region;
    logic [15:0]        sw_meta;
    logic [15:0]        sw_sync;
    logic [15:0]        timer;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               overflow;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               ovf_set;
    logic               ovf_clr;
    logic               wr_ram;
    logic               wr_led;
    logic               wr_timer;
    logic [15:0]        status;
    logic [15:0]        rd_next;
    logic               unused_addr_bits;

    assign region   = bus.Addr[15:12];
    assign ram_idx  = bus.Addr[RAM_AW-1:0];
    assign unused_addr_bits = ^bus.Addr[11:RAM_AW];

    assign wr_ram   = bus.W && (region == 4'h0);
    assign wr_led   = bus.W && (region == 4'h1);
    assign wr_timer = bus.W && (region == 4'h3);
    assign push_req = bus.W && (region == 4'h4);
    assign ovf_clr  = bus.W && (region == 4'h5) && bus.WrData[0];

    assign fifo_full  = (count == CNT_MAX);
    assign fifo_empty = (count == '0);
    assign fifo_valid = !fifo_empty;
    assign fifo_data  = fifo_mem[rd_ptr];
    assign pop        = fifo_valid && fifo_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign status     = {overflow, fifo_full, fifo_empty, 5'b0, 8'(count)};

    always_comb begin
        rd_next = '0;
        case (region)
            4'h0:    rd_next = ram[ram_idx];
            4'h1:    rd_next = led_out;
            4'h2:    rd_next = sw_sync;
            4'h3:    rd_next = timer;
            4'h4:    rd_next = status;
            default: rd_next = '0;
        endcase
    end

    // Storage arrays have no reset. Clear only blocks writes on its edge.
    always_ff @(posedge Clock) begin
        if (!Clear && wr_ram)
            ram[ram_idx] <= bus.WrData;
        if (!Clear && push_ok)
            fifo_mem[wr_ptr] <= bus.WrData;
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            bus.RdData <= '0;
            led_out    <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
            timer      <= '0;
        end else begin
            bus.RdData <= rd_next;
            sw_meta    <= SW;
            sw_sync    <= sw_meta;
            if (wr_led)
                led_out <= bus.WrData;
            if (wr_timer)
                timer <= bus.WrData;
            else
                timer <= timer + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A new overflow wins over a clear request arriving on the same edge.
            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_target.sv
// Directed vector bench for bus_target.
// It has a table of single-edge vectors plus short hand-written multi-cycle sequences.
module tb_bus_target;

    typedef struct {
        string       name;
        logic        clr;
        logic        w;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rdy;
        logic [15:0] sw;
        int          exp_rd;
        int          exp_led;
        int          exp_fv;
        int          exp_fd;
    } vec_t;

    logic        clock;
    logic        clear;
    logic [15:0] sw;
    logic [15:0] led_out;
    logic [15:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_ready;

    int   num_checks;
    int   num_fail;
    vec_t vecs[$];

    bus_target_if bus ();

    bus_target #(.RAM_AW(8), .FIFO_AW(2)) dut (
        .Clock      (clock),
        .Clear      (clear),
        .bus        (bus.slave),
        .SW         (sw),
        .led_out    (led_out),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_ready (fifo_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // A value of -1 in any expected field means that output is not checked for this vector.
    task automatic addVec(input string name, input logic clr, input logic w, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic rdy, input logic [15:0] swv,
                          input int rd, input int led, input int fv, input int fd);
        vec_t v;
        v.name = name; v.clr = clr; v.w = w; v.addr = addr; v.wdata = wdata;
        v.rdy = rdy; v.sw = swv; v.exp_rd = rd; v.exp_led = led; v.exp_fv = fv; v.exp_fd = fd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic clr, input logic w, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic rdy, input logic [15:0] swv);
        @(negedge clock);
        clear       = clr;
        bus.W       = w;
        bus.Addr    = addr;
        bus.WrData  = wdata;
        fifo_ready  = rdy;
        sw          = swv;
    endtask

    task automatic checkOutput(input vec_t v);
        if (v.exp_rd >= 0)  check({v.name, ".rd"},  bus.RdData, 16'(v.exp_rd));
        if (v.exp_led >= 0) check({v.name, ".led"}, led_out, 16'(v.exp_led));
        if (v.exp_fv >= 0)  check({v.name, ".fv"},  {15'd0, fifo_valid}, 16'(v.exp_fv));
        if (v.exp_fd >= 0)  check({v.name, ".fd"},  fifo_data, 16'(v.exp_fd));
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.clr, v.w, v.addr, v.wdata, v.rdy, v.sw);
        @(posedge clock);
        #1;
        checkOutput(v);
    endtask

    initial begin
        int cycles;
        num_checks = 0;
        num_fail   = 0;
        clear = 1'b1; bus.W = 1'b0; bus.Addr = '0; bus.WrData = '0; fifo_ready = 1'b0; sw = '0;

        //      name          clr w  addr     wdata    rdy sw       rd      led     fv  fd
        addVec("reset",       1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 'h0000, 'h0000, 0, -1);
        addVec("ram_wr5",     0, 1, 16'h0005, 16'hBEEF, 0, 16'h0000, -1,     -1,     -1, -1);
        addVec("ram_alias",   0, 1, 16'h0105, 16'h1234, 0, 16'h0000, 'hBEEF, -1,     -1, -1);
        addVec("ram_rd5",     0, 0, 16'h0005, 16'h0000, 0, 16'h0000, 'h1234, -1,     -1, -1);
        addVec("ram_rdw",     0, 1, 16'h0005, 16'h5555, 0, 16'h0000, 'h1234, -1,     -1, -1);
        addVec("ram_rdw2",    0, 0, 16'h0005, 16'h0000, 0, 16'h0000, 'h5555, -1,     -1, -1);
        addVec("led_wr",      0, 1, 16'h1000, 16'h00A5, 0, 16'h0000, 'h0000, 'h00A5, -1, -1);
        addVec("led_rd",      0, 0, 16'h1000, 16'h0000, 0, 16'h0000, 'h00A5, 'h00A5, -1, -1);
        addVec("sw_wr",       0, 1, 16'h2000, 16'hFFFF, 0, 16'h0000, 'h0000, 'h00A5, -1, -1);
        addVec("sw_rd",       0, 0, 16'h2000, 16'h0000, 0, 16'h0000, 'h0000, -1,     -1, -1);
        addVec("tmr_ld",      0, 1, 16'h3000, 16'hFFFE, 0, 16'h0000, -1,     -1,     -1, -1);
        addVec("tmr0",        0, 0, 16'h3000, 16'h0000, 0, 16'h0000, 'hFFFE, -1,     -1, -1);
        addVec("tmr1",        0, 0, 16'h3000, 16'h0000, 0, 16'h0000, 'hFFFF, -1,     -1, -1);
        addVec("tmr2",        0, 0, 16'h3000, 16'h0000, 0, 16'h0000, 'h0000, -1,     -1, -1);
        addVec("tmr3",        0, 0, 16'h3000, 16'h0000, 0, 16'h0000, 'h0001, -1,     -1, -1);
        addVec("push11",      0, 1, 16'h4000, 16'h0011, 0, 16'h0000, 'h2000, -1,     1,  'h0011);
        addVec("push22",      0, 1, 16'h4000, 16'h0022, 0, 16'h0000, 'h0001, -1,     1,  'h0011);
        addVec("push33",      0, 1, 16'h4000, 16'h0033, 0, 16'h0000, 'h0002, -1,     1,  'h0011);
        addVec("push44",      0, 1, 16'h4000, 16'h0044, 0, 16'h0000, 'h0003, -1,     1,  'h0011);
        addVec("stat_full",   0, 0, 16'h4000, 16'h0000, 0, 16'h0000, 'h4004, -1,     1,  'h0011);
        addVec("push55_ovf",  0, 1, 16'h4000, 16'h0055, 0, 16'h0000, 'h4004, -1,     1,  'h0011);
        addVec("stat_ovf",    0, 0, 16'h4000, 16'h0000, 0, 16'h0000, 'hC004, -1,     1,  'h0011);
        addVec("ctrl_clr",    0, 1, 16'h5000, 16'h0001, 0, 16'h0000, 'h0000, -1,     -1, -1);
        addVec("stat_clr",    0, 0, 16'h4000, 16'h0000, 0, 16'h0000, 'h4004, -1,     -1, -1);
        addVec("push_pop",    0, 1, 16'h4000, 16'h0055, 1, 16'h0000, 'h4004, -1,     1,  'h0022);
        addVec("drain1",      0, 0, 16'h4000, 16'h0000, 1, 16'h0000, 'h4004, -1,     1,  'h0033);
        addVec("drain2",      0, 0, 16'h4000, 16'h0000, 1, 16'h0000, 'h0003, -1,     1,  'h0044);
        addVec("drain3",      0, 0, 16'h4000, 16'h0000, 1, 16'h0000, 'h0002, -1,     1,  'h0055);
        addVec("drain4",      0, 0, 16'h4000, 16'h0000, 1, 16'h0000, 'h0001, -1,     0,  -1);
        addVec("stat_empty",  0, 0, 16'h4000, 16'h0000, 0, 16'h0000, 'h2000, -1,     0,  -1);
        addVec("sw_chg",      0, 0, 16'h2000, 16'h0000, 0, 16'h3C3C, 'h0000, -1,     -1, -1);
        addVec("sw_sync1",    0, 0, 16'h2000, 16'h0000, 0, 16'h3C3C, 'h0000, -1,     -1, -1);
        addVec("sw_sync2",    0, 0, 16'h2000, 16'h0000, 0, 16'h3C3C, 'h3C3C, -1,     -1, -1);
        addVec("led_ff",      0, 1, 16'h1000, 16'h00FF, 0, 16'h3C3C, -1,     'h00FF, -1, -1);
        addVec("pushAA",      0, 1, 16'h4000, 16'h00AA, 0, 16'h3C3C, -1,     -1,     1,  'h00AA);
        addVec("pushBB",      0, 1, 16'h4000, 16'h00BB, 0, 16'h3C3C, -1,     -1,     1,  'h00AA);
        addVec("ram_wr7",     0, 1, 16'h0007, 16'h7777, 0, 16'h3C3C, -1,     'h00FF, 1,  -1);
        addVec("clr_mid",     1, 1, 16'h0007, 16'h9999, 0, 16'h3C3C, 'h0000, 'h0000, 0,  -1);
        addVec("tmr_after",   0, 0, 16'h3000, 16'h0000, 0, 16'h3C3C, 'h0000, -1,     0,  -1);
        addVec("ram7_kept",   0, 0, 16'h0007, 16'h0000, 0, 16'h3C3C, 'h7777, -1,     -1, -1);
        addVec("stat_reset",  0, 0, 16'h4000, 16'h0000, 0, 16'h3C3C, 'h2000, -1,     -1, -1);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Free-running timer after a mid-range load.
        drive(0, 1, 16'h3000, 16'h0010, 0, 16'h3C3C);
        @(posedge clock);
        drive(0, 0, 16'h3000, 16'h0000, 0, 16'h3C3C);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("tmr_run%0d", i), bus.RdData, 16'h0010 + 16'(i));
            if (i < 4) @(negedge clock);
        end

        // Push into an empty FIFO. fifo_valid must rise on exactly the next cycle.
        drive(0, 1, 16'h4000, 16'h0077, 0, 16'h3C3C);
        #1;
        check("no_bypass", {15'd0, fifo_valid}, 16'd0);
        cycles = 0;
        @(posedge clock);
        #1;
        drive(0, 0, 16'h0000, 16'h0000, 0, 16'h3C3C);
        while (!fifo_valid && cycles < 8) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        check("valid_latency", 16'(cycles), 16'd0);
        check("push77_data", fifo_data, 16'h0077);

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/bus_target.md
Name: bus_target

Overview:
- Memory-mapped responder for the processor's bus: ADDR, DOUT and W come from the processor; RdData goes back to it as DIN.
- Decodes ADDR[15:12] into six regions: word RAM, LED register, synchronized switch input, free-running timer, console output FIFO, and FIFO control.
- Replaces the ad-hoc RAM/chip-select/LED glue at the processor's top level with one block.
- Has a fixed one-cycle read latency, so the processor needs no wait states.

Parameters:
RAM_AW, 8, RAM address width; RAM holds 2**RAM_AW 16-bit words.
FIFO_AW, 2, FIFO address width; console FIFO holds 2**FIFO_AW 16-bit entries.

Ports:
Clock  in  1  single system clock; all state changes on its rising edge.
Clear  in  1  synchronous, active-high reset.
Addr  in  16  bus address from the processor ADDR register.
WrData  in  16  write data from the processor DOUT register.
W  in  1  write strobe; a write commits on the edge where W=1.
RdData  out  16  registered read data, fed to the processor DIN.
SW  in  16  asynchronous switch inputs.
led_out  out  16  LED register.
fifo_data  out  16  console FIFO head entry.
fifo_valid  out  1  FIFO non-empty.
fifo_ready  in  1  consumer accepts the head entry.

Behaviour:
- Reset (Clear=1 at an edge):
  - Cleared to 0: RdData, led_out, timer, FIFO pointers and count, overflow flag, both SW synchronizer stages.
  - fifo_valid=0.
  - RAM contents are not cleared.
  - Clear overrides every simultaneous write, push and pop.
- Region decode on Addr[15:12]:
  - 0x0 RAM: index Addr[RAM_AW-1:0]; bits above are ignored, so the RAM aliases within the region.
  - 0x1 LED: read/write.
  - 0x2 SW: read-only; writes ignored.
  - 0x3 timer: read/write.
  - 0x4 FIFO: a write pushes WrData; a read returns status.
  - 0x5 FIFO control: a write with WrData[0]=1 clears the overflow flag; reads return 0.
  - 0x6-0xF: reads return 0; writes ignored.
- Read timing:
  - Every edge, RdData <= data selected by Addr sampled at that edge.
  - Valid the cycle after Addr is presented; there is no read strobe.
  - Reads have no side effects.
- RAM:
  - Write when W=1 and region 0x0.
  - Same-address read during write is read-first: RdData shows the old word; the new word is visible one cycle later.
- LED: a write loads led_out on the same edge; led_out updates the cycle after the write edge.
- SW:
  - Two-flop synchronizer, so SW reaches the readable register 2 edges after it changes.
  - A read returns the synchronized value.
- Timer:
  - 16-bit counter, +1 every edge, wraps 0xFFFF -> 0x0000.
  - A write loads WrData instead of incrementing that edge; counting resumes from WrData on the next edge.
- FIFO:
  - Circular buffer with pointers and a count from 0 to 2**FIFO_AW.
  - fifo_data = entry at the read pointer; fifo_valid = (count != 0).
  - pop = fifo_valid & fifo_ready.
  - push = W & region 0x4.
  - A push is accepted if count < depth, or if full and pop occurs the same edge.
  - A push rejected while full is dropped and sets the sticky overflow flag.
  - Simultaneous accepted push and pop leaves the count unchanged.
  - Push into an empty FIFO: fifo_valid rises the next cycle; no same-cycle bypass.
  - Pointers wrap modulo depth.
  - Status read format: bit15 = overflow, bit14 = full, bit13 = empty, bits[7:0] = count, all other bits 0.
  - Overflow is cleared only by a control write or Clear; a control write and a new overflow on the same edge leave overflow=1.
- Mid-operation reset drops all FIFO contents. The RAM retains its contents, and a RAM write on the same edge as Clear is suppressed.

Test Plan:
- Reset then RAM round-trip: Clear 1 cycle; write 0xBEEF to 0x0005 and 0x1234 to 0x0105 (aliases to index 5 with RAM_AW=8); read 0x0005 -> RdData=0x1234 one cycle later. Read-during-write at 0x0005 with data 0x5555 -> RdData=0x1234, then 0x5555 next cycle.
- LED/SW: write 0x00A5 to 0x1000 -> led_out=0x00A5 and read 0x1000 returns 0x00A5. Set SW=0x3C3C and read 0x2000 continuously -> RdData=0x3C3C no earlier than the 3rd cycle after the SW change. Write 0xFFFF to 0x2000 -> no effect.
- Timer: write 0xFFFE to 0x3000, then read 0x3000 on consecutive cycles -> RdData sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001 (first value on the cycle after the load edge).
- FIFO fill/overflow (FIFO_AW=2, fifo_ready=0): push 0x11, 0x22, 0x33, 0x44 -> status 0x4004. Push 0x55 -> status 0xC004 and the FIFO is unchanged. Write 1 to 0x5000 -> status 0x4004.
- FIFO drain and simultaneous events: with the FIFO full, hold fifo_ready=1 and push 0x55 on the same edge -> accepted, no overflow, count stays 4. Keep draining -> fifo_data sequence 0x22, 0x33, 0x44, 0x55; after the last pop, fifo_valid=0 and status=0x2000.
- Reset mid-operation: FIFO holds 2 entries, led_out=0x00FF, timer running; assert Clear together with W=1 to 0x0007 -> next cycle fifo_valid=0, led_out=0, timer=0, RdData=0; RAM[7] is unchanged.
